// File: rtl/pool_row_emitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pool_row_emitter                                                 |
// | Purpose  : Picks the F-1 vertical-max slice, applies warm-up and stride, and |
// |            buffers pooled rows in a small FIFO toward the writeback stream.  |
// | Options  : POOL_ROW_RELU_EN - clamp negative elements to zero before FIFO.   |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module pool_row_emitter #(
    parameter int DATA_WIDTH      = 32,
    parameter int SA_LENGTH       = 10,
    parameter int MAX_FILTER_SIZE = 7,
    parameter int MAX_STRIDE      = 7,
    parameter int FIFO_DEPTH      = 4,
    parameter int ROW_CNT_W       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(MAX_FILTER_SIZE+1)-1:0] cfg_filter_size,
    input  logic [$clog2(MAX_STRIDE+1)-1:0]      cfg_stride,
    input  logic [ROW_CNT_W-1:0]                 cfg_out_rows,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         VMaxs [MAX_FILTER_SIZE][SA_LENGTH],
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [DATA_WIDTH-1:0]         out_row [SA_LENGTH],
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 cfg_err
);

    localparam int c_fw    = $clog2(MAX_FILTER_SIZE+1);
    localparam int c_sw    = $clog2(MAX_STRIDE+1);
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_aw + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [c_fw-1:0]           r_f;
    logic [c_sw-1:0]           r_s;
    logic [ROW_CNT_W-1:0]      r_out_rows;
    logic [c_fw-1:0]           r_warm;
    logic [c_sw-1:0]           r_stride;
    logic [ROW_CNT_W-1:0]      r_pushed;
    logic                      r_cfg_err;

    logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH][SA_LENGTH];
    logic                      r_last_mem [FIFO_DEPTH];
    logic [c_aw-1:0]           r_wr_ptr;
    logic [c_aw-1:0]           r_rd_ptr;
    logic [c_cnt_w-1:0]        r_count;

    logic                      w_cfg_legal;
    logic                      w_full;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_xfer;
    logic                      w_emit;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_last;
    logic [c_fw-1:0]           w_sel;
    logic signed [DATA_WIDTH-1:0] w_push_row [SA_LENGTH];

    assign w_cfg_legal = (cfg_filter_size != '0) &&
                         (32'(cfg_filter_size) <= 32'(MAX_FILTER_SIZE)) &&
                         (cfg_stride != '0) &&
                         (32'(cfg_stride) <= 32'(MAX_STRIDE)) &&
                         (cfg_out_rows != '0);

    assign w_full      = (r_count == c_full_cnt);
    assign w_out_valid = (r_count != '0);
    assign w_in_ready  = (r_state == ST_RUN) && !w_full;
    assign w_xfer      = in_valid && w_in_ready;
    // A row is emitted once warm-up has expired and the stride phase is at zero.
    assign w_emit      = (r_warm == '0) && (r_stride == '0);
    assign w_push      = w_xfer && w_emit;
    assign w_pop       = w_out_valid && out_ready;
    assign w_last      = (r_pushed == (r_out_rows - ROW_CNT_W'(1)));
    assign w_sel       = r_f - c_fw'(1);

    generate
        for (genvar gc = 0; gc < SA_LENGTH; gc++) begin : g_push_col
`ifdef POOL_ROW_RELU_EN
            assign w_push_row[gc] = VMaxs[w_sel][gc][DATA_WIDTH-1] ? '0 : VMaxs[w_sel][gc];
`else
            assign w_push_row[gc] = VMaxs[w_sel][gc];
`endif
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && w_cfg_legal) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_push && w_last)     w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_count == '0)        w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_f        <= '0;
            r_s        <= '0;
            r_out_rows <= '0;
            r_warm     <= '0;
            r_stride   <= '0;
            r_pushed   <= '0;
            r_cfg_err  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == ST_IDLE) && start) begin
                if (w_cfg_legal) begin
                    r_f        <= cfg_filter_size;
                    r_s        <= cfg_stride;
                    r_out_rows <= cfg_out_rows;
                    r_warm     <= cfg_filter_size - c_fw'(1);
                    r_stride   <= '0;
                    r_pushed   <= '0;
                    r_cfg_err  <= 1'b0;
                end else begin
                    r_cfg_err  <= 1'b1;
                end
            end

            if (w_xfer) begin
                if (r_warm != '0) begin
                    r_warm <= r_warm - c_fw'(1);
                end else if (r_stride == '0) begin
                    r_stride <= r_s - c_sw'(1);
                end else begin
                    r_stride <= r_stride - c_sw'(1);
                end
            end

            if (w_push) begin
                r_pushed <= r_pushed + ROW_CNT_W'(1);
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int c = 0; c < SA_LENGTH; c++) begin
                r_mem[r_wr_ptr][c] <= w_push_row[c];
            end
            r_last_mem[r_wr_ptr] <= w_last;
        end
    end

    generate
        for (genvar gc = 0; gc < SA_LENGTH; gc++) begin : g_out_col
            assign out_row[gc] = w_out_valid ? r_mem[r_rd_ptr][gc] : '0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_valid && r_last_mem[r_rd_ptr];
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
